// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath widths, canonical NOP encoding, default reset PC.
// Latency: n/a (constants only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [XLEN-1:0] RESET_PC = '0;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} fetch entries; flush empties it in one edge.
// Latency: a pushed entry is visible on head_data right after the pushing edge.
// Backpressure: push is ignored when full unless a pop frees a slot on the same edge.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_data  write one entry
//   pop              retire head entry (ignored when empty)
//   flush            drop all entries; wins over push/pop
//   head_data        oldest entry (undefined while count == 0)
//   count            number of valid entries
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: it is only read through a non-zero count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, streams word reads to imem, queues returns for decode.
// Latency: a response is pushed on the edge that samples it and is on if_* right after that edge.
// Backpressure: issue stops once queued + live in-flight entries reach FQ_DEPTH (credit limit).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   imem_req, imem_addr           word read request (memory never stalls)
//   imem_rvalid, imem_rdata       in-order responses, one per request
//   redirect_valid, redirect_pc   taken branch / jump target from execute
//   if_valid, if_ready            handshake to decode
//   if_pc, if_pc4, if_instr       head entry, zero while the queue is empty
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              ADDR_W   = 8,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int              FQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [ILEN-1:0]   imem_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [XLEN-1:0]   if_pc,
  output logic [XLEN-1:0]   if_pc4,
  output logic [ILEN-1:0]   if_instr
);

  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int EW = XLEN + ILEN;

  localparam logic [CW:0]   CREDITS = (CW + 1)'(FQ_DEPTH);
  localparam logic [CW-1:0] OUT_MAX = '1;
  localparam logic [XLEN-1:0] WORD  = XLEN'(4);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   q_count;

  logic [XLEN-1:0] target;
  logic [CW:0]     in_use;
  logic            retire;
  logic            discard;
  logic            q_push;
  logic            q_pop;
  logic [EW-1:0]   head_data;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_instr;

  assign target = redirect_pc & ~XLEN'(3);

  // Responses already marked for dropping will never occupy a queue slot,
  // so they do not consume credit.
  assign in_use = {1'b0, q_count} + {1'b0, outstanding} - {1'b0, drop_cnt};

  // The OUT_MAX guard only matters for memories slower than the counter
  // range; it stalls issue instead of letting outstanding wrap.
  assign imem_req  = !rst && !redirect_valid && (in_use < CREDITS) && (outstanding != OUT_MAX);
  assign imem_addr = pc[ADDR_W+1:2];

  // A response with nothing outstanding is a protocol error and is ignored.
  assign retire  = imem_rvalid && (outstanding != '0);
  assign discard = retire && (drop_cnt != '0);
  assign q_push  = retire && !discard && !redirect_valid;
  assign q_pop   = if_valid && if_ready && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      pc          <= target;
      resp_pc     <= target;
      // Everything still in flight after this edge belongs to the old path.
      outstanding <= outstanding - CW'(retire);
      drop_cnt    <= outstanding - CW'(retire);
    end else begin
      if (imem_req) pc      <= pc + WORD;
      if (q_push)   resp_pc <= resp_pc + WORD;
      outstanding <= outstanding + CW'(imem_req) - CW'(retire);
      if (discard)  drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data ({resp_pc, imem_rdata}),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head_data (head_data),
    .count     (q_count)
  );

  assign head_pc    = head_data[EW-1:ILEN];
  assign head_instr = head_data[ILEN-1:0];

  assign if_valid = (q_count != '0);
  assign if_pc    = if_valid ? head_pc        : '0;
  assign if_pc4   = if_valid ? head_pc + WORD : '0;
  assign if_instr = if_valid ? head_instr     : '0;

endmodule
